// File: rtl/seq_scan_arbiter_if.sv
// Requester/result bundle for the shared serial pattern-scan engine.
// The slave modport is the scan engine; the master modport is the producer/consumer side.
interface seq_scan_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ),
  parameter int CW   = $clog2(W + 1)
) ();
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [CW-1:0]     res_count;

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_count
  );

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_count
  );
endinterface

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding a single time-shared, MSB-first, overlapping
// 4-bit pattern detector. One word is scanned at a time; the match count is
// returned with the requester id over a valid/ready result port.
module seq_scan_arbiter #(
  parameter int         NREQ = 4,
  parameter int         W    = 8,
  parameter logic [3:0] PAT  = 4'b1001,
  parameter int         IDW  = $clog2(NREQ),
  parameter int         CW   = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  seq_scan_arbiter_if.slave bus,
  output logic              hit,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_shreg;
  logic [2:0]     r_window;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_bitcnt;
  logic           r_res_valid;
  logic           r_busy;

  logic [IDW-1:0]  w_cand;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_found;
  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic [W-1:0]    w_word;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [3:0]      w_window_nxt;
  logic            w_match;

  // Round-robin search: first valid requester at or after r_ptr, with wrap-around.
  always_comb begin
    w_cand    = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = IDW'((32'(r_ptr) + i) % NREQ);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Grant only while idle and out of reset, so req_ready stays low during reset.
  always_comb begin
    w_grant = '0;
    if ((r_state == ST_IDLE) && !rst && w_found) begin
      w_grant = NREQ'(1) << w_gnt_idx;
    end
  end

  // Select the granted requester's word.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_word = bus.req_data[i*W +: W];
      end
    end
  end

  assign w_xfer       = |w_grant;
  assign w_ptr_nxt    = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  // Only the last three bits need storing; the fourth is the bit shifted out now.
  assign w_window_nxt = {r_window, r_shreg[W-1]};
  assign w_match      = (r_state == ST_SHIFT) && (r_bitcnt >= CW'(3)) &&
                        (w_window_nxt == PAT);

  assign bus.req_ready = w_grant;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_id;
  assign bus.res_count = r_count;
  assign hit           = w_match;
  assign busy          = r_busy;

  // Control FSM: accept a word, scan it bit by bit, then hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_shreg     <= '0;
      r_window    <= '0;
      r_count     <= '0;
      r_bitcnt    <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_shreg  <= w_word;
            r_id     <= w_gnt_idx;
            r_ptr    <= w_ptr_nxt;
            r_window <= '0;
            r_count  <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shreg  <= {r_shreg[W-2:0], 1'b0};
          r_window <= w_window_nxt[2:0];
          if (w_match && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
          end
          if (r_bitcnt == CW'(W - 1)) begin
            r_res_valid <= 1'b1;
            r_state     <= ST_RESULT;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        ST_RESULT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
